// File: rtl/key_debouncer_pkg.sv
// Shared types and constants for the push-button debouncer.
// Optional long-press support is enabled with KEY_DEBOUNCER_LONG_PRESS_EN.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } kd_state_t;

  localparam int KD_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser, async active-high reset.
// Output is the input delayed by KD_SYNC_STAGES clock edges.
module sync_2ff
  import key_debouncer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [KD_SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[KD_SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[KD_SYNC_STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer: synchroniser, 4-state filter FSM, press/release pulses, toggle.
// Define KEY_DEBOUNCER_LONG_PRESS_EN to add the long_press output and hold counter.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
  ,
  parameter int LONG_PRESS_CYCLES = 50000000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

  logic [HW-1:0] r_hold;
  logic          r_lp_done;
  logic          r_long;
`endif

  logic          w_key_s;
  kd_state_t     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;
  logic          r_toggle;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (key_in),
    .o_q (w_key_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
      r_hold    <= '0;
      r_lp_done <= 1'b0;
      r_long    <= 1'b0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      unique case (r_state)
        RELEASED: begin
          if (w_key_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!w_key_s) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state  <= PRESSED;
            r_cnt    <= '0;
            r_level  <= 1'b1;
            r_press  <= 1'b1;
            r_toggle <= ~r_toggle;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!w_key_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (w_key_s) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end
      endcase
`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
      // Fires once per accepted press; a bounce through RELEASE_WAIT restarts the hold.
      r_long <= 1'b0;
      if (r_state == PRESSED && w_key_s) begin
        if (r_hold != HOLD_MAX) begin
          r_hold <= r_hold + HW'(1);
        end
        if (!r_lp_done && r_hold == HOLD_LAST) begin
          r_long    <= 1'b1;
          r_lp_done <= 1'b1;
          r_toggle  <= 1'b0;
        end
      end else begin
        r_hold <= '0;
      end
      if (r_state == PRESS_WAIT) begin
        r_lp_done <= 1'b0;
      end
`endif
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_toggle  = r_toggle;
`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
  assign long_press  = r_long;
`endif

endmodule
